// File: rtl/tt_sweep_reader.sv
// Sweeps all 2^N_IN input vectors into an attached gate and captures its output as a truth table.
// Optional reference compare against EXPECTED is built when TT_SWEEP_COMPARE_EN is defined.
module tt_sweep_reader #(
  parameter int unsigned          N_IN     = 4,
  parameter int unsigned          SETTLE   = 2,
  parameter logic [(2**N_IN)-1:0] EXPECTED = 16'h616A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   tt,
  output logic                   match,
  output logic [N_IN-1:0]        first_err
);

  localparam int unsigned     W        = 2**N_IN;
  localparam logic [N_IN-1:0] LastIdx  = {N_IN{1'b1}};
  localparam logic [3:0]      SettleLd = 4'(SETTLE);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [W-1:0]    tt_q, tt_d;
  logic            clear, sample, last;

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    clear   = 1'b0;
    sample  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSweep;
          stim_d  = '0;
          cnt_d   = SettleLd;
          tt_d    = '0;
          clear   = 1'b1;
        end
      end
      StSweep: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          sample       = 1'b1;
          tt_d[stim_q] = dut_out;
          if (stim_q != LastIdx) begin
            stim_d = stim_q + N_IN'(1);
            cnt_d  = SettleLd;
          end else begin
            // Park the vector at 0 for the DONE cycle and idle.
            stim_d  = '0;
            last    = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stim_q  <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
    end
  end

  assign stim = stim_q;
  assign tt   = tt_q;
  assign busy = (state_q == StSweep);
  assign done = (state_q == StDone);

`ifdef TT_SWEEP_COMPARE_EN
  logic            err_seen_q, err_seen_d;
  logic            match_q, match_d;
  logic [N_IN-1:0] first_err_q, first_err_d;
  logic            mismatch;

  assign mismatch = sample && (dut_out != EXPECTED[stim_q]);

  always_comb begin
    err_seen_d  = err_seen_q;
    match_d     = match_q;
    first_err_d = first_err_q;
    if (clear) begin
      err_seen_d  = 1'b0;
      match_d     = 1'b0;
      first_err_d = '0;
    end
    // Only the lowest failing index is kept.
    if (mismatch && !err_seen_q) begin
      err_seen_d  = 1'b1;
      first_err_d = stim_q;
    end
    if (last) begin
      match_d = !(err_seen_q || mismatch);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seen_q  <= 1'b0;
      match_q     <= 1'b0;
      first_err_q <= '0;
    end else begin
      err_seen_q  <= err_seen_d;
      match_q     <= match_d;
      first_err_q <= first_err_d;
    end
  end

  assign match     = match_q;
  assign first_err = first_err_q;
`else
  logic unused_expected;
  assign unused_expected = ^{EXPECTED, sample, last, clear};
  assign match           = 1'b0;
  assign first_err       = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Scoreboard bench: a spec-level model predicts each sweep result; a negedge monitor checks it.
// A second instance (SETTLE=0) drives a gate with two registered output stages.
module tb_tt_sweep_reader;

  localparam int          S    = 2;
  localparam int          SF   = 0;
  localparam int          LEN  = 16 * (S + 1);
  localparam int          LENF = 16 * (SF + 1);
  localparam logic [15:0] EXP  = 16'h616A;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_f = 1'b0;
  logic [3:0]  stim, stim_f, first_err, first_err_f;
  logic        dut_out, dut_out_f, busy, busy_f, done, done_f, match, match_f;
  logic [15:0] tt, tt_f;
  logic [15:0] gate_tt = EXP, gate_tt_f = EXP;
  logic        p1, p2;

  always #5 clk = ~clk;

  assign dut_out = gate_tt[stim];
  always @(posedge clk) begin
    p1 <= gate_tt_f[stim_f];
    p2 <= p1;
  end
  assign dut_out_f = p2;

  tt_sweep_reader #(.N_IN(4), .SETTLE(S), .EXPECTED(EXP)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_out(dut_out),
    .busy(busy), .done(done), .tt(tt), .match(match), .first_err(first_err)
  );

  tt_sweep_reader #(.N_IN(4), .SETTLE(SF), .EXPECTED(EXP)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f), .stim(stim_f), .dut_out(dut_out_f),
    .busy(busy_f), .done(done_f), .tt(tt_f), .match(match_f), .first_err(first_err_f)
  );

  typedef struct {
    logic [15:0] tt;
    logic        m;
    logic [3:0]  fe;
    int          dcyc;
  } exp_t;

  exp_t q[$], qf[$];
  exp_t held, held_f;
  int   cyc = 0, free_at = 0, free_f = 0, e0 = -1000, e0f = -1000;
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t predict(input logic [15:0] t, input int d);
    exp_t e;
    e.tt = t; e.dcyc = d; e.m = 1'b0; e.fe = 4'd0;
`ifdef TT_SWEEP_COMPARE_EN
    e.m = (t == EXP);
    for (int i = 15; i >= 0; i--) if (t[i] != EXP[i]) e.fe = 4'(i);
`endif
    return e;
  endfunction

  // Two register stages with zero extra settle: vector i sees f(i-2), idle vector 0 before that.
  function automatic logic [15:0] delayed2(input logic [15:0] f);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = f[(i < 2) ? 0 : i - 2];
    return r;
  endfunction

  // Reference model: decides which starts are accepted and what each sweep must report.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); qf.delete();
      free_at = 0; free_f = 0; e0 = -1000; e0f = -1000;
      held   = '{tt: 16'h0, m: 1'b0, fe: 4'h0, dcyc: 0};
      held_f = '{tt: 16'h0, m: 1'b0, fe: 4'h0, dcyc: 0};
    end else begin
      cyc++;
      if (start && cyc >= free_at) begin
        e0 = cyc; free_at = cyc + LEN + 2;
        q.push_back(predict(gate_tt, cyc + LEN));
      end
      if (start_f && cyc >= free_f) begin
        e0f = cyc; free_f = cyc + LENF + 2;
        qf.push_back(predict(delayed2(gate_tt_f), cyc + LENF));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic eb, ebf;
    if (rst_n) begin
      eb  = (cyc >= e0) && (cyc < e0 + LEN);
      ebf = (cyc >= e0f) && (cyc < e0f + LENF);
      chk("busy", busy, eb);
      chk("done", done, q.size() > 0 && q[0].dcyc == cyc);
      if (done && q.size() > 0) begin
        e = q.pop_front();
        chk("tt", tt, e.tt); chk("match", match, e.m); chk("first_err", first_err, e.fe);
        held = e;
      end else if (!eb && !done) begin
        chk("hold_tt", tt, held.tt); chk("hold_match", match, held.m);
        chk("hold_first_err", first_err, held.fe);
      end
      chk("fast_busy", busy_f, ebf);
      chk("fast_done", done_f, qf.size() > 0 && qf[0].dcyc == cyc);
      if (done_f && qf.size() > 0) begin
        e = qf.pop_front();
        chk("fast_tt", tt_f, e.tt); chk("fast_match", match_f, e.m);
        chk("fast_first_err", first_err_f, e.fe);
        held_f = e;
      end else if (!ebf && !done_f) begin
        chk("fast_hold_tt", tt_f, held_f.tt);
      end
    end
  end

  task automatic sweep(input logic [15:0] f);
    @(negedge clk);
    gate_tt = f;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LEN + 3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep(EXP);
    sweep(16'h0000);
    sweep(16'hFFFF);

    // start re-asserted at vector 5 and held through done: must not restart.
    @(negedge clk); gate_tt = 16'h1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (16) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    chk("held_start_done_seen", done, 1'b1);
    start = 1'b0;
    repeat (4) @(negedge clk);
    gate_tt = 16'hBEEF;
    repeat (4) @(negedge clk);

    // Asynchronous reset at vector 9, checked with no clock edge in between.
    @(negedge clk); gate_tt = EXP; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9 * (S + 1) + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0); chk("rst_done", done, 1'b0); chk("rst_tt", tt, 16'h0);
    chk("rst_match", match, 1'b0); chk("rst_first_err", first_err, 4'h0);
    chk("rst_stim", stim, 4'h0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sweep(EXP);

    // Random tables and random start pulses, including during busy and done.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (cyc >= e0 + LEN && $urandom_range(0, 3) == 0) gate_tt = 16'($urandom);
      start = ($urandom_range(0, 9) == 0);
    end
    start = 1'b0;
    repeat (LEN + 4) @(negedge clk);

    // Registered gate with SETTLE=0 must not recover the table.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      gate_tt_f = (k == 0) ? EXP : 16'($urandom);
      repeat (4) @(negedge clk);
      start_f = 1'b1;
      @(negedge clk);
      start_f = 1'b0;
      repeat (LENF + 6) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(q.size() + qf.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_sweep_reader.md
# tt_sweep_reader

Sequential truth-table reader for 4-input combinational gate netlists. The block drives every input vector 0..15 into an attached gate, waits a programmable settle time, and samples the gate's single output into a 16-bit truth-table word. This is the inverse of a gate netlist: a gate maps inputs to one output bit, and this block reconstructs the hex truth table from that output. It sits in the characterization harness beside each synthesized gate and checks that the netlist realizes its intended function.

## Interface
Parameters:
- `N_IN`, default 4: gate input count; the truth table is 2^N_IN bits wide.
- `SETTLE`, default 2: extra hold cycles per vector before sampling; legal range 0..15.
- `EXPECTED`, default 16'h616A: reference truth table, used only when compare is compiled in.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: sweep request, sampled only in IDLE.
- `stim`, output, N_IN: vector driven to the gate inputs; `stim[k]` drives gate input k.
- `dut_out`, input, 1: gate output.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: one-cycle pulse when the truth table is complete.
- `tt`, output, 2^N_IN: captured truth table; bit i = `dut_out` observed with `stim` = i.
- `match`, output, 1: `tt` == `EXPECTED`, valid from `done` onward.
- `first_err`, output, N_IN: lowest index i where `tt[i]` != `EXPECTED[i]`, valid when `match` = 0.

## Operation
- State machine:
  - IDLE: `busy` = 0.
  - On `start` = 1, go to SWEEP: clear `tt` to 0, set `stim` = 0, load the settle counter with `SETTLE`, clear `match` and `first_err`.
  - SWEEP: when the counter is nonzero, decrement it. When it is 0, write `tt[stim]` <= `dut_out`.
    - If `stim` != 2^N_IN-1: increment `stim` and reload the counter with `SETTLE`.
    - Otherwise: go to DONE.
  - DONE: lasts one cycle. `done` = 1, `busy` = 0, `stim` returns to 0, then go to IDLE.
- `start` is ignored in SWEEP and DONE. There is no queuing, and a held `start` restarts only from IDLE.
- `tt`, `match` and `first_err` hold their values after DONE until the next accepted `start`.
- `stim` is a plain binary count with no wrap beyond 2^N_IN-1; the sweep always terminates after the last index.
- Reset values, forced asynchronously at any time including mid-sweep: state IDLE, `stim` = 0, `busy` = 0, `done` = 0, `tt` = 0, `match` = 0, `first_err` = 0. A partial sweep is discarded.

## Timing
- Let E0 be the edge at which `start` is accepted.
  - `stim` = 0 and `busy` = 1 from E0.
  - Vector i is driven from edge E0 + i·(SETTLE+1).
  - Vector i is sampled at edge E0 + (i+1)·(SETTLE+1).
- The gate therefore has SETTLE+1 full cycles of combinational settling per vector.
- `done` is high in the cycle after the final sample edge E0 + 16·(SETTLE+1). With defaults, this is the cycle after E0 + 48.
- `tt`, `match` and `first_err` are final on the same edge that raises `done`.
- Back-to-back sweeps: `start` high during the `done` cycle is ignored. The earliest accepted `start` is the cycle after `done`.

## Configuration
- Macro `TT_SWEEP_COMPARE_EN`.
- Defined: each sample is compared with `EXPECTED[i]`.
  - `first_err` latches the first mismatching index during the sweep.
  - `match` registers 1 at DONE if no mismatch occurred, else 0.
- Undefined: no compare logic is built. `match` and `first_err` are tied to 0 and `EXPECTED` is unused.

## Test plan
- Behavioral 0x616A gate, `SETTLE` = 2, `start` pulse → `done` in the cycle after E0 + 48; `tt` = 16'h616A; `match` = 1 (compare enabled).
- Gate stubbed to constant 0 → `tt` = 16'h0000, `match` = 0, `first_err` = 1. Constant 1 → `tt` = 16'hFFFF, `first_err` = 0.
- `start` re-asserted at vector 5 and held through `done` → no restart, `tt` unchanged. A new sweep begins only on a `start` after returning to IDLE.
- `rst_n` pulsed low at vector 9 → all outputs at reset values immediately with no clock. A fresh `start` yields the correct 16'h616A.
- Gate with 2 registered output stages: `SETTLE` = 0 → `tt` != 16'h616A and `match` = 0; `SETTLE` = 2 → `tt` = 16'h616A.
- Build without `TT_SWEEP_COMPARE_EN` → `match` = 0 and `first_err` = 0 throughout; `tt` and `done` timing are identical to the enabled build.
